data_bus_responder: RTL and testbench

Memory-side responder for the single-cycle ARM core's data port. It takes the core's address, write data and write strobe, and returns read data in the same cycle. Reads are combinational, which is required because the core consumes ReadData in the same cycle it issues the address. Behind the port sit a word RAM and an MMIO page: LED register, free-running cycle counter, and a byte transmit FIFO drained by a downstream valid/ready consumer.

---
 rtl/data_bus_responder.sv | 139 +++++++++++++
 tb/tb_data_bus_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Data-port responder for the single-cycle core: word RAM plus an MMIO page
// (LED, cycle counter, byte TX FIFO). Reads are combinational; writes land on the clock edge.
module data_bus_responder #(
    parameter int RAM_AW  = 7,
    parameter int FIFO_AW = 3,
    parameter int LED_W   = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [31:0]      Addr,
    input  logic [31:0]      WriteData,
    input  logic             MemWrite,
    output logic [31:0]      ReadData,
    output logic [LED_W-1:0] LED,
    output logic [7:0]       TxData,
    output logic             TxValid,
    input  logic             TxReady,
    output logic             BusErr
);

    localparam int RAM_WORDS  = 2 ** RAM_AW;
    localparam int FIFO_DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = FIFO_DEPTH[FIFO_AW:0];

    localparam logic [5:0] OFF_LED = 6'h00;
    localparam logic [5:0] OFF_CYC = 6'h01;
    localparam logic [5:0] OFF_TXD = 6'h02;
    localparam logic [5:0] OFF_STS = 6'h03;

    logic [31:0]      ram_q [RAM_WORDS];
    logic [7:0]       fifo_q [FIFO_DEPTH];

    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      cycle_q, cycle_d;
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             buserr_q, buserr_d;

    logic              is_ram, is_mmio, known_off;
    logic [RAM_AW-1:0] ram_idx;
    logic [5:0]        mmio_off;
    logic              ram_we, mmio_we, wr_led, wr_cyc, wr_txd, wr_sts, bad_wr;
    logic [FIFO_AW:0]  count;
    logic              fifo_empty, fifo_full, pop, push_ok, push_drop;
    logic [31:0]       status, rdata;
    logic              unused_addr_bits;

    assign is_ram    = (Addr[31:28] == 4'h0);
    assign is_mmio   = (Addr[31:28] == 4'hF);
    assign ram_idx   = Addr[RAM_AW+1:2];
    assign mmio_off  = Addr[7:2];
    assign known_off = (mmio_off[5:2] == 4'h0);
    assign unused_addr_bits = ^{Addr[27:RAM_AW+2], Addr[1:0]};

    // Reset masks every write strobe so nothing lands in the reset cycle.
    assign ram_we  = MemWrite && is_ram && !Reset;
    assign mmio_we = MemWrite && is_mmio && !Reset;
    assign wr_led  = mmio_we && (mmio_off == OFF_LED);
    assign wr_cyc  = mmio_we && (mmio_off == OFF_CYC);
    assign wr_txd  = mmio_we && (mmio_off == OFF_TXD);
    assign wr_sts  = mmio_we && (mmio_off == OFF_STS);
    assign bad_wr  = MemWrite && ((!is_ram && !is_mmio) || (is_mmio && !known_off));

    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign pop        = !fifo_empty && TxReady;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = wr_txd && (!fifo_full || pop);
    assign push_drop  = wr_txd && fifo_full && !pop;

    always_comb begin
        led_d    = led_q;
        cycle_d  = cycle_q + 32'd1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        buserr_d = buserr_q | bad_wr;
        if (wr_led)                 led_d    = WriteData[LED_W-1:0];
        if (wr_cyc)                 cycle_d  = '0;
        if (push_ok)                wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)                    rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_sts && WriteData[2]) ovf_d    = 1'b0;
        if (push_drop)              ovf_d    = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            led_q    <= '0;
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            led_q    <= led_d;
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            buserr_q <= buserr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (ram_we)  ram_q[ram_idx] <= WriteData;
        if (push_ok) fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= WriteData[7:0];
    end

    always_comb begin
        status = '0;
        status[0] = fifo_empty;
        status[1] = fifo_full;
        status[2] = ovf_q;
        status[FIFO_AW+8:8] = count;
    end

    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = ram_q[ram_idx];
        end else if (is_mmio) begin
            case (mmio_off)
                OFF_LED: rdata[LED_W-1:0] = led_q;
                OFF_CYC: rdata = cycle_q;
                OFF_STS: rdata = status;
                default: rdata = '0;
            endcase
        end
    end

    assign ReadData = rdata;
    assign LED      = led_q;
    assign TxData   = fifo_q[rd_ptr_q[FIFO_AW-1:0]];
    assign TxValid  = !fifo_empty;
    assign BusErr   = buserr_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: a cycle-per-row vector table for the
// main bus/FIFO behaviour, plus hand sequences for counter, bus errors and mid-stream reset.
module tb_data_bus_responder;

    localparam logic [31:0] A_LED = 32'hF000_0000;
    localparam logic [31:0] A_CYC = 32'hF000_0004;
    localparam logic [31:0] A_TXD = 32'hF000_0008;
    localparam logic [31:0] A_STS = 32'hF000_000C;
    localparam logic [31:0] A_BAD = 32'h2000_0000;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [7:0]  LED;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;
    logic        BusErr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t tbl[$];

    data_bus_responder #(.RAM_AW(7), .FIFO_AW(3), .LED_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .Addr(Addr), .WriteData(WriteData),
        .MemWrite(MemWrite), .ReadData(ReadData), .LED(LED), .TxData(TxData),
        .TxValid(TxValid), .TxReady(TxReady), .BusErr(BusErr)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wd,
                                input logic we, input logic rdy, input logic chk_rd,
                                input logic [31:0] exp_rd, input logic exp_txv,
                                input logic [7:0] exp_txd);
        vec_t v;
        v.addr = addr; v.wd = wd; v.we = we; v.rdy = rdy;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_txv = exp_txv; v.exp_txd = exp_txd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic rdy);
        Addr = a; WriteData = wd; MemWrite = we; TxReady = rdy;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        set_in(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        Reset = 1'b0;

        // Reset state, counter start, LED
        tbl.push_back(mk(A_CYC, 0, 0, 0, 1, 32'd0, 0, 8'h00));
        tbl.push_back(mk(A_CYC, 0, 0, 0, 1, 32'd1, 0, 8'h00));
        tbl.push_back(mk(A_LED, 32'h0000_00A5, 1, 0, 1, 32'h0, 0, 8'h00));
        tbl.push_back(mk(A_LED, 0, 0, 0, 1, 32'h0000_00A5, 0, 8'h00));
        // RAM write, same-cycle old read, aliasing
        tbl.push_back(mk(32'h0000_0010, 32'hCAFE_F00D, 1, 0, 0, 32'h0, 0, 8'h00));
        tbl.push_back(mk(32'h0000_0010, 32'h1234_5678, 1, 0, 1, 32'hCAFE_F00D, 0, 8'h00));
        tbl.push_back(mk(32'h0000_0010, 0, 0, 0, 1, 32'h1234_5678, 0, 8'h00));
        tbl.push_back(mk(32'h0000_0210, 0, 0, 0, 1, 32'h1234_5678, 0, 8'h00));
        // FIFO ordering
        tbl.push_back(mk(A_TXD, 32'h11, 1, 0, 1, 32'h0, 0, 8'h00));
        tbl.push_back(mk(A_TXD, 32'h22, 1, 0, 1, 32'h0, 1, 8'h11));
        tbl.push_back(mk(A_TXD, 32'h33, 1, 0, 1, 32'h0, 1, 8'h11));
        tbl.push_back(mk(A_STS, 0, 0, 0, 1, 32'h0000_0300, 1, 8'h11));
        tbl.push_back(mk(A_STS, 0, 0, 1, 1, 32'h0000_0300, 1, 8'h11));
        tbl.push_back(mk(A_STS, 0, 0, 1, 1, 32'h0000_0200, 1, 8'h22));
        tbl.push_back(mk(A_STS, 0, 0, 1, 1, 32'h0000_0100, 1, 8'h33));
        tbl.push_back(mk(A_STS, 0, 0, 0, 1, 32'h0000_0001, 0, 8'h00));
        // Fill past full, then drain
        for (int i = 1; i <= 9; i++)
            tbl.push_back(mk(A_TXD, 32'(i), 1, 0, 1, 32'h0, (i != 1), 8'h01));
        tbl.push_back(mk(A_STS, 0, 0, 0, 1, 32'h0000_0806, 1, 8'h01));
        tbl.push_back(mk(A_STS, 0, 0, 1, 1, 32'h0000_0806, 1, 8'h01));
        for (int i = 2; i <= 8; i++)
            tbl.push_back(mk(A_STS, 0, 0, 1, 1, 32'((9 - i) << 8) | 32'h4, 1, 8'(i)));
        tbl.push_back(mk(A_STS, 0, 0, 0, 1, 32'h0000_0005, 0, 8'h00));
        tbl.push_back(mk(A_STS, 32'h4, 1, 0, 1, 32'h0000_0005, 0, 8'h00));
        tbl.push_back(mk(A_STS, 0, 0, 0, 1, 32'h0000_0001, 0, 8'h00));
        // Refill, then simultaneous push/pop while full
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(A_TXD, 32'hA0 + 32'(i), 1, 0, 1, 32'h0, (i != 0), 8'hA0));
        tbl.push_back(mk(A_STS, 0, 0, 0, 1, 32'h0000_0802, 1, 8'hA0));
        tbl.push_back(mk(A_TXD, 32'hA8, 1, 1, 1, 32'h0, 1, 8'hA0));
        tbl.push_back(mk(A_STS, 0, 0, 0, 1, 32'h0000_0802, 1, 8'hA1));

        chk("reset_led", 32'(LED), 32'h0);
        chk("reset_buserr", 32'(BusErr), 32'h0);

        foreach (tbl[i]) begin
            set_in(tbl[i].addr, tbl[i].wd, tbl[i].we, tbl[i].rdy);
            #2;
            if (tbl[i].chk_rd) chk($sformatf("row%0d_rdata", i), ReadData, tbl[i].exp_rd);
            chk($sformatf("row%0d_txvalid", i), 32'(TxValid), 32'(tbl[i].exp_txv));
            if (tbl[i].exp_txv) chk($sformatf("row%0d_txdata", i), 32'(TxData), 32'(tbl[i].exp_txd));
            tick();
        end
        chk("led_port", 32'(LED), 32'h0000_00A5);

        // Cycle counter clear
        set_in(A_CYC, 32'h0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 100; i++) begin
            set_in(A_BAD, 32'h0, 1'b0, 1'b0);
            tick();
        end
        set_in(A_CYC, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #2 chk("cycle_at_100", ReadData, 32'd100);
        tick();
        set_in(A_CYC, 32'h0, 1'b0, 1'b0);
        #2 chk("cycle_after_clear", ReadData, 32'd0);
        tick();
        #2 chk("cycle_after_clear_p1", ReadData, 32'd1);
        chk("buserr_before", 32'(BusErr), 32'h0);

        // Unmapped write sets sticky BusErr
        set_in(A_BAD, 32'h1, 1'b1, 1'b0);
        tick();
        set_in(A_BAD, 32'h0, 1'b0, 1'b0);
        #2 chk("buserr_set", 32'(BusErr), 32'h1);
        chk("unmapped_read", ReadData, 32'h0);
        repeat (3) tick();
        chk("buserr_sticky", 32'(BusErr), 32'h1);

        // Drain leftovers, then queue 5 bytes and reset mid-stream
        set_in(A_STS, 32'h0, 1'b0, 1'b1);
        repeat (8) tick();
        TxReady = 1'b0;
        #2 chk("drained_status", ReadData, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            set_in(A_TXD, 32'hB0 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        set_in(A_STS, 32'h0, 1'b0, 1'b1);
        #2 chk("queued_status", ReadData, 32'h0000_0500);
        tick();
        TxReady = 1'b0;
        tick();
        TxReady = 1'b1;
        tick();
        Reset = 1'b1;
        set_in(A_LED, 32'hFF, 1'b1, 1'b1);
        tick();
        Reset = 1'b0;
        set_in(A_STS, 32'h0, 1'b0, 1'b0);
        #2 chk("rst_txvalid", 32'(TxValid), 32'h0);
        chk("rst_status", ReadData, 32'h0000_0001);
        chk("rst_buserr", 32'(BusErr), 32'h0);
        chk("rst_led_write_ignored", 32'(LED), 32'h0);
        Addr = A_CYC;
        #1 chk("rst_cycle", ReadData, 32'd0);
        Addr = 32'h0000_0010;
        #1 chk("rst_ram_kept", ReadData, 32'h1234_5678);
        tick();

        // Write to an unknown MMIO offset
        set_in(32'hF000_0020, 32'h55, 1'b1, 1'b0);
        tick();
        set_in(32'hF000_0020, 32'h0, 1'b0, 1'b0);
        #2 chk("badoff_buserr", 32'(BusErr), 32'h1);
        chk("badoff_led", 32'(LED), 32'h0);
        chk("badoff_read", ReadData, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
